branch_resolve_ctrl: RTL and testbench
======================================

# branch_resolve_ctrl

In-order branch resolution controller sitting between decode (which issues static/dynamic predictions) and the execute-stage branch unit. Tracks up to DEPTH in-flight predicted branches in a FIFO, compares each against its resolved outcome, and on a mispredict issues a registered fetch redirect, squashes all younger in-flight branches and holds a timed pipeline flush. Gates new branch issue while full or flushing.

## Interface
- DEPTH, 4: max in-flight predicted branches (power of two, ≥2)
- FLUSH_CYCLES, 2: cycles `flush` is held after a mispredict (≥1)

- clk  in  1  clock
- rst  in  1  synchronous, active-high reset
- pred_valid  in  1  decode issues a branch with prediction
- pred_pc  in  32  branch PC
- pred_taken  in  1  predicted direction
- pred_target  in  32  predicted target (don't-care when not taken)
- pred_ready  out  1  branch may be accepted this cycle
- res_valid  in  1  execute resolves the oldest in-flight branch
- res_taken  in  1  actual direction
- res_target  in  32  actual target (don't-care when not taken)
- redirect_valid  out  1  one-cycle fetch redirect pulse
- redirect_pc  out  32  corrected fetch PC
- flush  out  1  squash younger pipeline state
- inflight_cnt  out  $clog2(DEPTH+1)  occupied entries
- err_underflow  out  1  sticky: res_valid seen with empty FIFO

## Operation
- States: RUN, FLUSH. Reset → RUN, FIFO empty, all outputs 0 except pred_ready=1.
- Push: pred_valid && pred_ready stores {pc, taken, target}.
- pred_ready = (state==RUN) && (inflight_cnt < DEPTH), from registered count only; push+pop when full is not accepted.
- Resolve (RUN, FIFO non-empty): pop oldest; mispredict = (res_taken != e.taken) || (res_taken && res_target != e.target).
- Correct: pop only; concurrent push allowed, count unchanged.
- Mispredict: next cycle redirect_valid=1, redirect_pc = res_taken ? res_target : e.pc+4 (32-bit wrap); FIFO cleared (count→0); concurrent push in the same cycle dropped; state→FLUSH.
- FLUSH: flush=1, pred_ready=0, res_valid ignored; down-counter from FLUSH_CYCLES; at zero → RUN.
- res_valid with empty FIFO (RUN): ignored, err_underflow set until rst.
- Pointers wrap modulo DEPTH.
- rst mid-FLUSH or with entries pending: immediate return to reset state; no redirect emitted.

## Timing
- Resolve at cycle t (mispredict): redirect_valid and first flush cycle at t+1; flush high t+1..t+FLUSH_CYCLES; pred_ready high again at t+FLUSH_CYCLES+1.
- inflight_cnt updates the cycle after push/pop.
- redirect_valid exactly one cycle; redirect_pc holds last value otherwise (reset 0).
- Push to resolve of same entry: earliest next cycle (no same-cycle bypass).

## Configuration
- BRC_PERF_CNT_EN defined: adds outputs perf_branches[31:0] (resolves counted) and perf_mispred[31:0] (mispredicts), reset 0, saturating at 32'hFFFF_FFFF.
- Undefined: ports and counters absent; all other behaviour identical.

## Structure
- isa_pkg: bp_entry_t {pc, taken, target}, brc_state_e {RUN, FLUSH}.
- One sub-module: brc_fifo (DEPTH-entry sync FIFO of bp_entry_t with clear input, head/tail wrap, count).
- Controller FSM, compare, redirect register and optional perf counters in top.

## Test plan
- Push pc=0x100 taken=0; resolve taken=0 → no redirect, inflight_cnt 1→0, flush=0.
- Push pc=0x200 not-taken; resolve taken=1 target=0x400 → t+1 redirect_valid=1, redirect_pc=0x400; flush for 2 cycles; pred_ready back at t+3.
- Push taken target=0x500; resolve taken target=0x504 → redirect_pc=0x504; 3 younger entries squashed, inflight_cnt=0.
- Push 4 branches → pred_ready=0; push+correct resolve while full → push rejected, count=3 next cycle.
- res_valid with empty FIFO → err_underflow=1, held until rst; rst asserted mid-FLUSH → next cycle flush=0, pred_ready=1, count=0.
- With BRC_PERF_CNT_EN: 10 resolves, 3 mispredicts → perf_branches=10, perf_mispred=3.

Source files
------------

// File: rtl/isa_pkg.sv
// rtl/isa_pkg.sv - branch prediction entry and controller state types
package isa_pkg;

  typedef struct packed {
    logic [31:0] pc;
    logic        taken;
    logic [31:0] target;
  } bp_entry_t;

  typedef enum logic [0:0] {
    RUN   = 1'b0,
    FLUSH = 1'b1
  } brc_state_e;

endpackage

// File: rtl/branch_resolve_ctrl_if.sv
// rtl/branch_resolve_ctrl_if.sv - decode/execute/fetch bus of the branch resolve controller (BRC_PERF_CNT_EN adds perf outputs)
interface branch_resolve_ctrl_if #(
  parameter int DEPTH = 4
);
  logic                           pred_valid;
  logic [31:0]                    pred_pc;
  logic                           pred_taken;
  logic [31:0]                    pred_target;
  logic                           pred_ready;
  logic                           res_valid;
  logic                           res_taken;
  logic [31:0]                    res_target;
  logic                           redirect_valid;
  logic [31:0]                    redirect_pc;
  logic                           flush;
  logic [$clog2(DEPTH+1)-1:0]     inflight_cnt;
  logic                           err_underflow;
`ifdef BRC_PERF_CNT_EN
  logic [31:0]                    perf_branches;
  logic [31:0]                    perf_mispred;
`endif

  modport master (
    output pred_valid, pred_pc, pred_taken, pred_target,
    output res_valid, res_taken, res_target,
    input  pred_ready, redirect_valid, redirect_pc, flush, inflight_cnt, err_underflow
`ifdef BRC_PERF_CNT_EN
    , input perf_branches, perf_mispred
`endif
  );

  modport slave (
    input  pred_valid, pred_pc, pred_taken, pred_target,
    input  res_valid, res_taken, res_target,
    output pred_ready, redirect_valid, redirect_pc, flush, inflight_cnt, err_underflow
`ifdef BRC_PERF_CNT_EN
    , output perf_branches, perf_mispred
`endif
  );

endinterface

// File: rtl/brc_fifo.sv
// rtl/brc_fifo.sv - DEPTH-entry synchronous FIFO of predicted branches with clear
module brc_fifo
  import isa_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       clear,
  input  logic                       push,
  input  bp_entry_t                  push_data,
  input  logic                       pop,
  output bp_entry_t                  head_data,
  output logic [$clog2(DEPTH+1)-1:0] count
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);

  bp_entry_t       mem [DEPTH];
  logic [AW-1:0]   head;
  logic [AW-1:0]   tail;

  assign head_data = mem[head];

  // entry storage; no reset needed, validity is tracked by count
  always_ff @(posedge clk) begin
    if (push) begin
      mem[tail] <= push_data;
    end
  end

  // pointers wrap naturally since DEPTH is a power of two; clear drops everything
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      if (push) tail <= tail + AW'(1);
      if (pop)  head <= head + AW'(1);
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end
endmodule

// File: rtl/branch_resolve_ctrl.sv
// rtl/branch_resolve_ctrl.sv - in-order branch resolution, redirect and timed flush (BRC_PERF_CNT_EN adds perf counters)
module branch_resolve_ctrl
  import isa_pkg::*;
#(
  parameter int DEPTH        = 4,
  parameter int FLUSH_CYCLES = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  branch_resolve_ctrl_if.slave  bus
);
  localparam int CW = $clog2(DEPTH+1);
  localparam int FW = $clog2(FLUSH_CYCLES+1);
  localparam logic [CW-1:0] DEPTH_C  = CW'(DEPTH);
  localparam logic [0:0]    ST_RUN   = 1'(RUN);
  localparam logic [0:0]    ST_FLUSH = 1'(FLUSH);

  logic [0:0]    state;
  logic [FW-1:0] flush_cnt;
  logic [CW-1:0] count;
  bp_entry_t     head;
  bp_entry_t     in_entry;
  logic          in_run;
  logic          push_ok;
  logic          resolve;
  logic          mispred;
  logic          redirect_valid_q;
  logic [31:0]   redirect_pc_q;
  logic          err_q;

  assign in_run   = (state == ST_RUN);
  assign push_ok  = bus.pred_valid && bus.pred_ready;
  assign resolve  = in_run && bus.res_valid && (count != '0);
  assign mispred  = resolve && ((bus.res_taken != head.taken) ||
                                (bus.res_taken && (bus.res_target != head.target)));
  assign in_entry = '{pc: bus.pred_pc, taken: bus.pred_taken, target: bus.pred_target};

  brc_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .clear     (mispred),
    .push      (push_ok && !mispred),
    .push_data (in_entry),
    .pop       (resolve && !mispred),
    .head_data (head),
    .count     (count)
  );

  assign bus.pred_ready     = in_run && (count < DEPTH_C);
  assign bus.flush          = (state == ST_FLUSH);
  assign bus.inflight_cnt   = count;
  assign bus.redirect_valid = redirect_valid_q;
  assign bus.redirect_pc    = redirect_pc_q;
  assign bus.err_underflow  = err_q;

  // RUN/FLUSH sequencing: a mispredict holds FLUSH for FLUSH_CYCLES cycles
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_RUN;
      flush_cnt <= '0;
    end else if (in_run) begin
      if (mispred) begin
        state     <= ST_FLUSH;
        flush_cnt <= FW'(FLUSH_CYCLES - 1);
      end
    end else if (flush_cnt == '0) begin
      state <= ST_RUN;
    end else begin
      flush_cnt <= flush_cnt - FW'(1);
    end
  end

  // one-cycle redirect pulse; the PC holds its last value between pulses
  always_ff @(posedge clk) begin
    if (rst) begin
      redirect_valid_q <= 1'b0;
      redirect_pc_q    <= '0;
    end else begin
      redirect_valid_q <= mispred;
      if (mispred) begin
        redirect_pc_q <= bus.res_taken ? bus.res_target : head.pc + 32'd4;
      end
    end
  end

  // sticky flag for a resolve arriving with nothing in flight
  always_ff @(posedge clk) begin
    if (rst) begin
      err_q <= 1'b0;
    end else if (in_run && bus.res_valid && (count == '0)) begin
      err_q <= 1'b1;
    end
  end

`ifdef BRC_PERF_CNT_EN
  logic [31:0] perf_branches_q;
  logic [31:0] perf_mispred_q;

  assign bus.perf_branches = perf_branches_q;
  assign bus.perf_mispred  = perf_mispred_q;

  // saturating counts of resolves and mispredicts
  always_ff @(posedge clk) begin
    if (rst) begin
      perf_branches_q <= '0;
      perf_mispred_q  <= '0;
    end else begin
      if (resolve && (perf_branches_q != '1)) perf_branches_q <= perf_branches_q + 32'd1;
      if (mispred && (perf_mispred_q != '1))  perf_mispred_q  <= perf_mispred_q + 32'd1;
    end
  end
`endif
endmodule

// File: tb/tb_branch_resolve_ctrl.sv
// tb/tb_branch_resolve_ctrl.sv - directed table-driven bench for branch_resolve_ctrl
module tb_branch_resolve_ctrl;
  import isa_pkg::*;

  logic clk;
  logic rst;
  int   n_checks;
  int   n_fail;

  branch_resolve_ctrl_if #(.DEPTH(4)) bus ();

  branch_resolve_ctrl #(.DEPTH(4), .FLUSH_CYCLES(2)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        rst;
    logic        pv;
    logic [31:0] ppc;
    logic        pt;
    logic [31:0] ptg;
    logic        rv;
    logic        rt;
    logic [31:0] rtg;
    logic        e_ready;
    logic        e_rv;
    logic [31:0] e_rpc;
    logic        e_fl;
    logic [2:0]  e_cnt;
    logic        e_err;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t v(logic r, logic pv, logic [31:0] ppc, logic pt, logic [31:0] ptg,
                             logic rv, logic rt, logic [31:0] rtg,
                             logic e_ready, logic e_rv, logic [31:0] e_rpc, logic e_fl,
                             logic [2:0] e_cnt, logic e_err);
    vec_t x;
    x.rst = r; x.pv = pv; x.ppc = ppc; x.pt = pt; x.ptg = ptg;
    x.rv = rv; x.rt = rt; x.rtg = rtg;
    x.e_ready = e_ready; x.e_rv = e_rv; x.e_rpc = e_rpc; x.e_fl = e_fl;
    x.e_cnt = e_cnt; x.e_err = e_err;
    return x;
  endfunction

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic chk_all(string tag, logic e_ready, logic e_rv, logic [31:0] e_rpc,
                         logic e_fl, logic [2:0] e_cnt, logic e_err);
    chk({tag, ".pred_ready"},     32'(bus.pred_ready),     32'(e_ready));
    chk({tag, ".redirect_valid"}, 32'(bus.redirect_valid), 32'(e_rv));
    chk({tag, ".redirect_pc"},    bus.redirect_pc,         e_rpc);
    chk({tag, ".flush"},          32'(bus.flush),          32'(e_fl));
    chk({tag, ".inflight_cnt"},   32'(bus.inflight_cnt),   32'(e_cnt));
    chk({tag, ".err_underflow"},  32'(bus.err_underflow),  32'(e_err));
  endtask

  task automatic idle_inputs();
    rst = 1'b0;
    bus.pred_valid = 1'b0; bus.pred_pc = '0; bus.pred_taken = 1'b0; bus.pred_target = '0;
    bus.res_valid = 1'b0;  bus.res_taken = 1'b0; bus.res_target = '0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    idle_inputs();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    idle_inputs();

    //          rst pv ppc           pt ptg     rv rt rtg      | rdy rv rpc          fl cnt err
    tbl.push_back(v(0, 1, 32'h100,      0, 32'h0,   0, 0, 32'h0,     1, 0, 32'h0,        0, 0, 0));
    tbl.push_back(v(0, 0, 32'h0,        0, 32'h0,   1, 0, 32'h0,     1, 0, 32'h0,        0, 1, 0));
    tbl.push_back(v(0, 0, 32'h0,        0, 32'h0,   0, 0, 32'h0,     1, 0, 32'h0,        0, 0, 0));
    tbl.push_back(v(0, 1, 32'h200,      0, 32'h0,   0, 0, 32'h0,     1, 0, 32'h0,        0, 0, 0));
    tbl.push_back(v(0, 0, 32'h0,        0, 32'h0,   1, 1, 32'h400,   1, 0, 32'h0,        0, 1, 0));
    tbl.push_back(v(0, 0, 32'h0,        0, 32'h0,   0, 0, 32'h0,     0, 1, 32'h400,      1, 0, 0));
    tbl.push_back(v(0, 0, 32'h0,        0, 32'h0,   1, 0, 32'h0,     0, 0, 32'h400,      1, 0, 0));
    tbl.push_back(v(0, 1, 32'h300,      1, 32'h500, 0, 0, 32'h0,     1, 0, 32'h400,      0, 0, 0));
    tbl.push_back(v(0, 1, 32'h310,      0, 32'h0,   0, 0, 32'h0,     1, 0, 32'h400,      0, 1, 0));
    tbl.push_back(v(0, 1, 32'h320,      0, 32'h0,   0, 0, 32'h0,     1, 0, 32'h400,      0, 2, 0));
    tbl.push_back(v(0, 1, 32'h330,      0, 32'h0,   0, 0, 32'h0,     1, 0, 32'h400,      0, 3, 0));
    tbl.push_back(v(0, 0, 32'h0,        0, 32'h0,   1, 1, 32'h504,   0, 0, 32'h400,      0, 4, 0));
    tbl.push_back(v(0, 0, 32'h0,        0, 32'h0,   0, 0, 32'h0,     0, 1, 32'h504,      1, 0, 0));
    tbl.push_back(v(0, 0, 32'h0,        0, 32'h0,   0, 0, 32'h0,     0, 0, 32'h504,      1, 0, 0));
    tbl.push_back(v(0, 1, 32'h400,      0, 32'h0,   0, 0, 32'h0,     1, 0, 32'h504,      0, 0, 0));
    tbl.push_back(v(0, 1, 32'h410,      0, 32'h0,   0, 0, 32'h0,     1, 0, 32'h504,      0, 1, 0));
    tbl.push_back(v(0, 1, 32'h420,      0, 32'h0,   0, 0, 32'h0,     1, 0, 32'h504,      0, 2, 0));
    tbl.push_back(v(0, 1, 32'h430,      0, 32'h0,   0, 0, 32'h0,     1, 0, 32'h504,      0, 3, 0));
    tbl.push_back(v(0, 1, 32'h440,      0, 32'h0,   1, 0, 32'h0,     0, 0, 32'h504,      0, 4, 0));
    tbl.push_back(v(0, 1, 32'h450,      0, 32'h0,   1, 1, 32'h800,   1, 0, 32'h504,      0, 3, 0));
    tbl.push_back(v(0, 0, 32'h0,        0, 32'h0,   0, 0, 32'h0,     0, 1, 32'h800,      1, 0, 0));
    tbl.push_back(v(0, 0, 32'h0,        0, 32'h0,   0, 0, 32'h0,     0, 0, 32'h800,      1, 0, 0));
    tbl.push_back(v(0, 1, 32'hFFFFFFFC, 1, 32'h40,  0, 0, 32'h0,     1, 0, 32'h800,      0, 0, 0));
    tbl.push_back(v(0, 0, 32'h0,        0, 32'h0,   1, 0, 32'h0,     1, 0, 32'h800,      0, 1, 0));
    tbl.push_back(v(0, 0, 32'h0,        0, 32'h0,   0, 0, 32'h0,     0, 1, 32'h0,        1, 0, 0));
    tbl.push_back(v(0, 0, 32'h0,        0, 32'h0,   0, 0, 32'h0,     0, 0, 32'h0,        1, 0, 0));
    tbl.push_back(v(0, 0, 32'h0,        0, 32'h0,   1, 0, 32'h0,     1, 0, 32'h0,        0, 0, 0));
    tbl.push_back(v(0, 0, 32'h0,        0, 32'h0,   0, 0, 32'h0,     1, 0, 32'h0,        0, 0, 1));
    tbl.push_back(v(0, 1, 32'h600,      1, 32'h700, 0, 0, 32'h0,     1, 0, 32'h0,        0, 0, 1));
    tbl.push_back(v(0, 0, 32'h0,        0, 32'h0,   1, 1, 32'h700,   1, 0, 32'h0,        0, 1, 1));
    tbl.push_back(v(0, 1, 32'h610,      0, 32'h0,   0, 0, 32'h0,     1, 0, 32'h0,        0, 0, 1));
    tbl.push_back(v(0, 0, 32'h0,        0, 32'h0,   1, 1, 32'h900,   1, 0, 32'h0,        0, 1, 1));
    tbl.push_back(v(1, 0, 32'h0,        0, 32'h0,   0, 0, 32'h0,     0, 1, 32'h900,      1, 0, 1));
    tbl.push_back(v(0, 1, 32'hA00,      0, 32'h0,   0, 0, 32'h0,     1, 0, 32'h0,        0, 0, 0));
    tbl.push_back(v(0, 1, 32'hA10,      0, 32'h0,   0, 0, 32'h0,     1, 0, 32'h0,        0, 1, 0));
    tbl.push_back(v(1, 0, 32'h0,        0, 32'h0,   0, 0, 32'h0,     1, 0, 32'h0,        0, 2, 0));
    tbl.push_back(v(0, 0, 32'h0,        0, 32'h0,   0, 0, 32'h0,     1, 0, 32'h0,        0, 0, 0));

    // reset state
    do_reset();
    #1;
    chk_all("reset", 1'b1, 1'b0, 32'h0, 1'b0, 3'd0, 1'b0);

    // table: expected outputs are those visible during the row's cycle
    foreach (tbl[i]) begin
      @(negedge clk);
      rst             = tbl[i].rst;
      bus.pred_valid  = tbl[i].pv;
      bus.pred_pc     = tbl[i].ppc;
      bus.pred_taken  = tbl[i].pt;
      bus.pred_target = tbl[i].ptg;
      bus.res_valid   = tbl[i].rv;
      bus.res_taken   = tbl[i].rt;
      bus.res_target  = tbl[i].rtg;
      #1;
      chk_all($sformatf("row%0d", i), tbl[i].e_ready, tbl[i].e_rv, tbl[i].e_rpc,
              tbl[i].e_fl, tbl[i].e_cnt, tbl[i].e_err);
    end

    // push and resolve in the same cycle on an empty FIFO: no bypass
    do_reset();
    @(negedge clk);
    bus.pred_valid = 1'b1; bus.pred_pc = 32'hB00; bus.pred_taken = 1'b0;
    bus.res_valid  = 1'b1; bus.res_taken = 1'b0;
    @(negedge clk);
    idle_inputs();
    #1;
    chk("nobypass.inflight_cnt",   32'(bus.inflight_cnt),   32'd1);
    chk("nobypass.err_underflow",  32'(bus.err_underflow),  32'd1);
    chk("nobypass.redirect_valid", 32'(bus.redirect_valid), 32'd0);
    bus.res_valid = 1'b1; bus.res_taken = 1'b0;
    @(negedge clk);
    idle_inputs();
    #1;
    chk("nobypass_pop.inflight_cnt",   32'(bus.inflight_cnt),   32'd0);
    chk("nobypass_pop.redirect_valid", 32'(bus.redirect_valid), 32'd0);

`ifdef BRC_PERF_CNT_EN
    // 10 resolves, mispredicts on iterations 0, 3, 6
    do_reset();
    for (int i = 0; i < 10; i++) begin
      bit mis;
      int waited;
      mis = (i % 3 == 0) && (i < 9);
      @(negedge clk);
      bus.pred_valid = 1'b1; bus.pred_pc = 32'hC00 + 32'(i * 4); bus.pred_taken = 1'b0;
      @(negedge clk);
      idle_inputs();
      bus.res_valid = 1'b1; bus.res_taken = mis; bus.res_target = 32'hD00;
      @(negedge clk);
      idle_inputs();
      waited = 0;
      while (!(bus.pred_ready && !bus.flush) && waited < 10) begin
        @(negedge clk);
        waited++;
      end
      if (waited >= 10) begin
        n_checks++;
        n_fail++;
        $display("FAIL perf.wait_ready: pred_ready still 0 after %0d cycles, expected 1", waited);
      end
    end
    #1;
    chk("perf_branches", bus.perf_branches, 32'd10);
    chk("perf_mispred",  bus.perf_mispred,  32'd3);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
